// File: rtl/gate_control_sequencer_if.sv
// Configuration and gate-output bundle for the gate control sequencer.
// The master drives GCL writes, timing and enables; the slave returns the applied gate state.
interface gate_control_sequencer_if;
  logic       i_gcl_wr;
  logic [4:0] iv_gcl_addr;
  logic [7:0] iv_gcl_wdata;
  logic [5:0] iv_gcl_length;
  logic [10:0] iv_slot_time;
  logic       i_gcl_enable;
  logic       i_cycle_start;
  logic [7:0] ov_gate_ctrl_vector;
  logic [4:0] ov_gcl_index;
  logic       o_slot_boundary;
  logic [1:0] ov_gcs_state;

  modport master (
    output i_gcl_wr, iv_gcl_addr, iv_gcl_wdata, iv_gcl_length, iv_slot_time,
           i_gcl_enable, i_cycle_start,
    input  ov_gate_ctrl_vector, ov_gcl_index, o_slot_boundary, ov_gcs_state
  );

  modport slave (
    input  i_gcl_wr, iv_gcl_addr, iv_gcl_wdata, iv_gcl_length, iv_slot_time,
           i_gcl_enable, i_cycle_start,
    output ov_gate_ctrl_vector, ov_gcl_index, o_slot_boundary, ov_gcs_state
  );
endinterface

// File: rtl/gate_control_sequencer.sv
// Time-aware gate control sequencer: steps through a 32-entry gate control list,
// applying one 8-bit gate vector per slot, restarted by the time-sync cycle start pulse.
module gate_control_sequencer (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  gate_control_sequencer_if.slave         gcs
);

  typedef enum logic [1:0] {
    DISABLE_S    = 2'd0,
    WAIT_START_S = 2'd1,
    RUN_S        = 2'd2
  } gcs_state_t;

  gcs_state_t  state, state_nxt;
  logic [7:0]  gcl [32];
  logic [10:0] slot_cnt, slot_cnt_nxt;
  logic [7:0]  gate_vec;
  logic [4:0]  gcl_idx;
  logic        slot_bnd;
  logic        load;
  logic [4:0]  load_idx;
  logic [5:0]  eff_len;
  logic [10:0] eff_slot;
  logic [5:0]  idx_inc;
  logic        slot_end;
  logic        exit_req;

  assign eff_len  = (gcs.iv_gcl_length > 6'd32) ? 6'd32 : gcs.iv_gcl_length;
  assign eff_slot = (gcs.iv_slot_time == 11'd0) ? 11'd1 : gcs.iv_slot_time;
  assign idx_inc  = {1'b0, gcl_idx} + 6'd1;
  // >= also closes a slot whose time was shortened below the current count
  assign slot_end = (slot_cnt >= (eff_slot - 11'd1));
  assign exit_req = !gcs.i_gcl_enable || (gcs.iv_gcl_length == 6'd0);

  always_comb begin
    state_nxt    = state;
    slot_cnt_nxt = '0;
    load         = 1'b0;
    load_idx     = '0;
    case (state)
      DISABLE_S: begin
        if (!exit_req) state_nxt = WAIT_START_S;
      end
      WAIT_START_S: begin
        if (exit_req) begin
          state_nxt = DISABLE_S;
        end else if (gcs.i_cycle_start) begin
          state_nxt = RUN_S;
          load      = 1'b1;
        end
      end
      RUN_S: begin
        if (exit_req) begin
          state_nxt = DISABLE_S;
        end else if (gcs.i_cycle_start) begin
          load = 1'b1;
        end else if (slot_end) begin
          load     = 1'b1;
          load_idx = (idx_inc >= eff_len) ? 5'd0 : idx_inc[4:0];
        end else begin
          slot_cnt_nxt = slot_cnt + 11'd1;
        end
      end
      default: state_nxt = DISABLE_S;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= DISABLE_S;
      slot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_cnt_nxt;
    end
  end

  // Gate vector only moves on an entry load, or falls back to all-open outside RUN_S
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gate_vec <= 8'hFF;
      gcl_idx  <= '0;
      slot_bnd <= 1'b0;
    end else begin
      slot_bnd <= load;
      if (load) begin
        gate_vec <= gcl[load_idx];
        gcl_idx  <= load_idx;
      end else if (state_nxt != RUN_S) begin
        gate_vec <= 8'hFF;
        gcl_idx  <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) gcl[i] <= 8'hFF;
    end else if (gcs.i_gcl_wr) begin
      gcl[gcs.iv_gcl_addr] <= gcs.iv_gcl_wdata;
    end
  end

  assign gcs.ov_gate_ctrl_vector = gate_vec;
  assign gcs.ov_gcl_index        = gcl_idx;
  assign gcs.o_slot_boundary     = slot_bnd;
  assign gcs.ov_gcs_state        = state;

endmodule

// File: tb/tb_gate_control_sequencer.sv
// Directed bench for gate_control_sequencer: schedule stepping, resync, wrap,
// shadowed writes, disable/reset exits, slot time 0 and GCL reset contents.
module tb_gate_control_sequencer;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  gate_control_sequencer_if gif ();

  gate_control_sequencer dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .gcs     (gif)
  );

  always #4 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic outs(input string tag, input logic [7:0] vec, input logic [4:0] idx,
                      input logic bnd, input logic [1:0] st);
    chk({tag, ".vec"}, gif.ov_gate_ctrl_vector, vec);
    chk({tag, ".idx"}, gif.ov_gcl_index, idx);
    chk({tag, ".bnd"}, gif.o_slot_boundary, bnd);
    chk({tag, ".st"},  gif.ov_gcs_state, st);
  endtask

  task automatic gcl_write(input logic [4:0] a, input logic [7:0] d);
    gif.i_gcl_wr     = 1'b1;
    gif.iv_gcl_addr  = a;
    gif.iv_gcl_wdata = d;
    step();
    gif.i_gcl_wr     = 1'b0;
  endtask

  task automatic pulse_start();
    gif.i_cycle_start = 1'b1;
    step();
    gif.i_cycle_start = 1'b0;
  endtask

  initial begin
    logic [7:0] sched [3];
    sched[0] = 8'h01; sched[1] = 8'h02; sched[2] = 8'h04;

    gif.i_gcl_wr      = 1'b0;
    gif.iv_gcl_addr   = '0;
    gif.iv_gcl_wdata  = '0;
    gif.iv_gcl_length = 6'd0;
    gif.iv_slot_time  = 11'd10;
    gif.i_gcl_enable  = 1'b0;
    gif.i_cycle_start = 1'b0;

    step(3);
    outs("reset", 8'hFF, 5'd0, 1'b0, 2'd0);
    i_rst_n = 1'b1;
    step();
    outs("idle", 8'hFF, 5'd0, 1'b0, 2'd0);

    gcl_write(5'd0, 8'h01);
    gcl_write(5'd1, 8'h02);
    gcl_write(5'd2, 8'h04);

    // Enable: waits in WAIT_START_S with all gates open
    gif.iv_gcl_length = 6'd3;
    gif.i_gcl_enable  = 1'b1;
    step();
    outs("wait", 8'hFF, 5'd0, 1'b0, 2'd1);
    step(4);
    outs("wait_hold", 8'hFF, 5'd0, 1'b0, 2'd1);

    // Basic schedule: 01/02/04 every 10 cycles, wrapping back to 01
    pulse_start();
    outs("run_e0", 8'h01, 5'd0, 1'b1, 2'd2);
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("sched_bnd%0d", k), gif.o_slot_boundary, (k % 10) == 0);
      chk($sformatf("sched_vec%0d", k), gif.ov_gate_ctrl_vector, sched[(k / 10) % 3]);
    end
    chk("wrap_idx", gif.ov_gcl_index, 5'd0);

    // Resync 15 cycles into the schedule
    step(14);
    chk("pre_resync_vec", gif.ov_gate_ctrl_vector, 8'h02);
    pulse_start();
    outs("resync", 8'h01, 5'd0, 1'b1, 2'd2);
    step(9);
    outs("resync_hold", 8'h01, 5'd0, 1'b0, 2'd2);
    step();
    outs("resync_next", 8'h02, 5'd1, 1'b1, 2'd2);

    // Cycle start coincident with slot expiry loads entry 0
    step(9);
    outs("coinc_pre", 8'h02, 5'd1, 1'b0, 2'd2);
    pulse_start();
    outs("coinc", 8'h01, 5'd0, 1'b1, 2'd2);

    // Length cut to 2 while entry 2 is active wraps to 0
    step(20);
    outs("len_idx2", 8'h04, 5'd2, 1'b1, 2'd2);
    step(5);
    gif.iv_gcl_length = 6'd2;
    step(5);
    outs("len_wrap", 8'h01, 5'd0, 1'b1, 2'd2);

    // Write to the active entry stays hidden until it is reloaded
    step(3);
    gcl_write(5'd0, 8'h80);
    chk("wr_hidden", gif.ov_gate_ctrl_vector, 8'h01);
    step(6);
    outs("wr_e1", 8'h02, 5'd1, 1'b1, 2'd2);
    step(10);
    outs("wr_reload", 8'h80, 5'd0, 1'b1, 2'd2);

    // Enable drop wins over a coincident cycle start
    step(4);
    gif.i_gcl_enable  = 1'b0;
    gif.i_cycle_start = 1'b1;
    step();
    gif.i_cycle_start = 1'b0;
    outs("disable", 8'hFF, 5'd0, 1'b0, 2'd0);
    step();
    chk("disable_hold", gif.ov_gcs_state, 2'd0);

    // Slot time 0 acts as 1; entry 3 still holds its reset value
    gif.iv_gcl_length = 6'd4;
    gif.iv_slot_time  = 11'd0;
    gif.i_gcl_enable  = 1'b1;
    step();
    chk("s1_wait", gif.ov_gcs_state, 2'd1);
    pulse_start();
    outs("s1_e0", 8'h80, 5'd0, 1'b1, 2'd2);
    step();
    outs("s1_e1", 8'h02, 5'd1, 1'b1, 2'd2);
    step();
    outs("s1_e2", 8'h04, 5'd2, 1'b1, 2'd2);
    step();
    outs("s1_e3", 8'hFF, 5'd3, 1'b1, 2'd2);
    step();
    outs("s1_wrap", 8'h80, 5'd0, 1'b1, 2'd2);

    // Zero length forces DISABLE_S
    gif.iv_gcl_length = 6'd0;
    step();
    outs("len0", 8'hFF, 5'd0, 1'b0, 2'd0);

    // Asynchronous reset mid-run, then a fresh cycle start is required
    gif.iv_gcl_length = 6'd3;
    gif.iv_slot_time  = 11'd10;
    step();
    pulse_start();
    chk("pre_rst_vec", gif.ov_gate_ctrl_vector, 8'h80);
    step(5);
    #2;
    i_rst_n = 1'b0;
    #1;
    outs("async_rst", 8'hFF, 5'd0, 1'b0, 2'd0);
    step(2);
    i_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("post_rst_bnd%0d", k), gif.o_slot_boundary, 1'b0);
    end
    outs("post_rst_wait", 8'hFF, 5'd0, 1'b0, 2'd1);
    pulse_start();
    outs("post_rst_e0", 8'hFF, 5'd0, 1'b1, 2'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_control_sequencer.md
GATE_CONTROL_SEQUENCER -- requirements
Module: gate_control_sequencer

Interface
REQ-001 i_clk  input  1  125 MHz system clock; all logic is on its rising edge.
REQ-002 i_rst_n  input  1  asynchronous, active-low reset.
REQ-003 i_gcl_wr  input  1  one-cycle write strobe for the gate control list (GCL).
REQ-004 iv_gcl_addr  input  5  GCL entry address, 0..31.
REQ-005 iv_gcl_wdata  input  8  gate vector for the entry; bit n = queue n gate open.
REQ-006 iv_gcl_length  input  6  number of valid entries, 0..32; 33..63 is treated as 32.
REQ-007 iv_slot_time  input  11  slot length in clock cycles; 0 is treated as 1.
REQ-008 i_gcl_enable  input  1  level; 1 = gate scheduling active.
REQ-009 i_cycle_start  input  1  one-cycle pulse from time sync marking the GCL cycle start.
REQ-010 ov_gate_ctrl_vector  output  8  registered gate vector to the output scheduler.
REQ-011 ov_gcl_index  output  5  registered index of the entry currently applied.
REQ-012 o_slot_boundary  output  1  one-cycle pulse when a new entry is applied.
REQ-013 ov_gcs_state  output  2  FSM state: 0 DISABLE_S, 1 WAIT_START_S, 2 RUN_S.

Function
REQ-014 The GCL shall be 32 x 8-bit registers, written when i_gcl_wr=1; a write takes effect in the cycle after the strobe.
REQ-015 DISABLE_S shall drive ov_gate_ctrl_vector=8'hFF and ov_gcl_index=0, with the slot counter held at 0.
REQ-016 DISABLE_S shall go to WAIT_START_S when i_gcl_enable=1 and iv_gcl_length!=0, and stay in DISABLE_S otherwise.
REQ-017 WAIT_START_S shall keep the outputs at 8'hFF / index 0 until i_cycle_start=1.
REQ-018 On i_cycle_start=1 in WAIT_START_S, the block shall enter RUN_S, set the slot counter to 0, and load entry 0.
REQ-019 Loading entry k shall drive ov_gate_ctrl_vector=GCL[k], ov_gcl_index=k and o_slot_boundary=1 in the next cycle (latency 1).
REQ-020 In RUN_S the slot counter shall increment every cycle.
REQ-021 When the slot counter equals the effective slot time minus 1, the counter shall clear to 0 and the next entry shall be loaded.
REQ-022 The next index shall be 0 when index+1 >= the effective length, and index+1 otherwise.
REQ-023 This wrap rule shall also apply when the length is reduced mid-cycle.
REQ-024 ov_gate_ctrl_vector shall change only on entry load, so a write to the active entry becomes visible only when that entry is next loaded.
REQ-025 i_cycle_start=1 in RUN_S shall resynchronise: counter to 0 and entry 0 loaded, taking precedence over a coincident slot expiry.
REQ-026 i_gcl_enable=0 or iv_gcl_length=0 in any state shall return the FSM to DISABLE_S, with outputs at 8'hFF / index 0 the next cycle.
REQ-027 The exit in REQ-026 shall take precedence over i_cycle_start in the same cycle.
REQ-028 o_slot_boundary shall be high for exactly one cycle per entry load, and 0 in all other cycles.
REQ-029 With effective slot time 1, an entry shall load every cycle and o_slot_boundary shall stay high continuously.
REQ-030 An unknown state encoding shall return the FSM to DISABLE_S with outputs at reset values.

Reset
REQ-031 On i_rst_n=0: all GCL entries=8'hFF, ov_gate_ctrl_vector=8'hFF, ov_gcl_index=0, o_slot_boundary=0, ov_gcs_state=DISABLE_S, slot counter=0.
REQ-032 Reset asserted mid-slot shall abort immediately, with no further slot_boundary pulse.
REQ-033 After reset release, the block shall wait for a new i_cycle_start before applying any entry.

Verification
REQ-034 GCL={8'h01,8'h02,8'h04}, length=3, slot=10, enable, cycle_start at T -> vector 01/02/04 at T+1/T+11/T+21, back to 01 at T+31; one boundary pulse at each.
REQ-035 Resync: cycle_start at T+15 during the previous run -> vector=01, index=0 at T+16; next change at T+26.
REQ-036 Slot expiry and cycle_start in the same cycle -> entry 0 loaded, not index+1.
REQ-037 Length reduced from 3 to 2 while index=2 -> next load is index 0.
REQ-038 Write 8'h80 to the active entry 0 mid-slot -> vector unchanged until entry 0 is reloaded, then 8'h80.
REQ-039 Enable dropped in RUN_S -> vector=FF, state=0 the next cycle; reset mid-run -> all outputs at reset values and a new cycle_start is required.
